// File: rtl/pixel_fifo.sv
// Synchronous single-clock pixel FIFO with registered read data and status flags.
// Define PIXEL_FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module pixel_fifo #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 4,
  parameter int PTR_WIDTH  = 10,
  parameter int AFULL_LVL  = DEPTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] AFULL_C  = AFULL_LVL[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AEMPTY_C = AEMPTY_LVL[PTR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH:0]    wptr_q, wptr_d;
  logic [PTR_WIDTH:0]    rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  wr_acc, rd_acc;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty        = (wptr_q == rptr_q);
  assign full         = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                        (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
  assign count        = wptr_q - rptr_q;
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    wr_acc       = 1'b0;
    rd_acc       = 1'b0;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      wr_acc = w_en & ~full;
      rd_acc = r_en & ~empty;
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) begin
        rptr_d       = rptr_q + 1'b1;
        data_out_d   = mem[rptr_q[PTR_WIDTH-1:0]];
        data_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage is never reset; stale contents are unreachable while empty.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wptr_q[PTR_WIDTH-1:0]] <= data_in;
  end

`ifdef PIXEL_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (w_en & full);
    underflow_d = underflow_q | (r_en & empty);
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
